// File: rtl/pixel_capture.sv
// -----------------------------------------------------------------------------
// pixel_capture
//   Captures frames from a parallel CMOS sensor bus. Input beats are assembled
//   into pixels (first beat in the MSBs). Pixels are emitted with frame
//   start/end markers. Malformed frames (partial pixel at line end, short or
//   overlong lines, extra lines, vsync rising before the last pixel) raise a
//   one-cycle frame_err pulse.
//
//   Optional feature: define CAP_ERR_CNT_EN to build a saturating 8-bit count
//   of frame_err pulses on err_cnt. Without it, err_cnt is tied to 0.
//
// Ports
//   clk        in   pixel clock
//   rst        in   asynchronous active-high reset
//   cmos_din   in   sensor data beat (IN_W bits)
//   cmos_vsync in   frame sync, active high; falling edge starts a frame
//   cmos_href  in   line valid, active high
//   cap_en     in   capture enable
//   pixel      out  assembled pixel (IN_W*PIX_BYTES bits)
//   pixel_vld  out  one-cycle pixel strobe
//   pixel_sop  out  first pixel of frame (with pixel_vld)
//   pixel_eop  out  last pixel of frame (with pixel_vld)
//   frame_err  out  one-cycle pulse per malformed frame
//   err_cnt    out  malformed-frame count (0 unless CAP_ERR_CNT_EN)
// -----------------------------------------------------------------------------
module pixel_capture #(
    parameter int IN_W        = 8,
    parameter int PIX_BYTES   = 2,
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int SKIP_FRAMES = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IN_W-1:0]           cmos_din,
    input  logic                      cmos_vsync,
    input  logic                      cmos_href,
    input  logic                      cap_en,
    output logic [IN_W*PIX_BYTES-1:0] pixel,
    output logic                      pixel_vld,
    output logic                      pixel_sop,
    output logic                      pixel_eop,
    output logic                      frame_err,
    output logic [7:0]                err_cnt
);

    localparam int PIX_W = IN_W * PIX_BYTES;
    localparam int X_W   = $clog2(IMG_W + 1);
    localparam int Y_W   = $clog2(IMG_H + 1);
    localparam int B_W   = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
    localparam int S_W   = $clog2(SKIP_FRAMES + 2);

    localparam logic [B_W-1:0] LAST_BEAT = B_W'(PIX_BYTES - 1);
    localparam logic [X_W-1:0] X_LAST    = X_W'(IMG_W - 1);
    localparam logic [X_W-1:0] X_FULL    = X_W'(IMG_W);
    localparam logic [Y_W-1:0] Y_LAST    = Y_W'(IMG_H - 1);
    localparam logic [Y_W-1:0] Y_FULL    = Y_W'(IMG_H);

    typedef enum logic [1:0] {IDLE, SKIP, WAIT_FS, ACTIVE} state_t;

    state_t state_reg, state_next;

    // Input registers and their delayed copies for edge detection
    logic [IN_W-1:0]  din_reg;
    logic             vsync_reg, vsync_dly_reg;
    logic             href_reg, href_dly_reg;

    logic [S_W-1:0]   skip_cnt_reg;
    logic [X_W-1:0]   x_reg;
    logic [Y_W-1:0]   y_reg;
    logic [B_W-1:0]   beat_reg;
    logic [PIX_W-1:0] asm_reg;
    logic             bad_reg;

    // Middle pipeline stage between assembly and the output registers
    logic             emit_reg, sop_stage_reg, eop_stage_reg, err_stage_reg;

    logic vsync_fall, vsync_rise, href_fall, in_range;
    logic frame_start, skip_inc, skip_clr;
    logic beat_ok, beat_over, line_end, abort, pix_done, eop_hit;
    logic line_bad;

    assign vsync_fall = vsync_dly_reg & ~vsync_reg;
    assign vsync_rise = ~vsync_dly_reg & vsync_reg;
    assign href_fall  = href_dly_reg & ~href_reg;
    assign in_range   = (x_reg < X_FULL) && (y_reg < Y_FULL);
    // Overlong lines leave x at X_FULL with beat 0 and are flagged per beat.
    assign line_bad   = (beat_reg != '0) || (x_reg != X_FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        frame_start = 1'b0;
        skip_inc    = 1'b0;
        skip_clr    = 1'b0;
        beat_ok     = 1'b0;
        beat_over   = 1'b0;
        line_end    = 1'b0;
        abort       = 1'b0;
        pix_done    = 1'b0;
        eop_hit     = 1'b0;
        case (state_reg)
            IDLE: begin
                // Every IDLE exit starts a fresh skip sequence.
                skip_clr = 1'b1;
                if (cap_en) begin
                    state_next = (SKIP_FRAMES == 0) ? WAIT_FS : SKIP;
                end
            end
            SKIP: begin
                if (!cap_en) begin
                    state_next = IDLE;
                end else if (vsync_fall) begin
                    skip_inc = 1'b1;
                    if (32'(skip_cnt_reg) + 32'd1 >= 32'(SKIP_FRAMES)) begin
                        state_next = WAIT_FS;
                    end
                end
            end
            WAIT_FS: begin
                if (!cap_en) begin
                    state_next = IDLE;
                end else if (vsync_fall) begin
                    frame_start = 1'b1;
                    state_next  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (vsync_rise) begin
                    // Frame ended before its last pixel: abort it.
                    abort      = 1'b1;
                    state_next = cap_en ? WAIT_FS : IDLE;
                end else if (href_reg) begin
                    if (in_range) begin
                        beat_ok = 1'b1;
                        if (beat_reg == LAST_BEAT) begin
                            pix_done = 1'b1;
                            if (x_reg == X_LAST && y_reg == Y_LAST) begin
                                eop_hit    = 1'b1;
                                state_next = cap_en ? WAIT_FS : IDLE;
                            end
                        end
                    end else begin
                        beat_over = 1'b1;
                    end
                end else if (href_fall) begin
                    line_end = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_reg       <= '0;
            vsync_reg     <= 1'b0;
            vsync_dly_reg <= 1'b0;
            href_reg      <= 1'b0;
            href_dly_reg  <= 1'b0;
            skip_cnt_reg  <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            beat_reg      <= '0;
            asm_reg       <= '0;
            bad_reg       <= 1'b0;
            emit_reg      <= 1'b0;
            sop_stage_reg <= 1'b0;
            eop_stage_reg <= 1'b0;
            err_stage_reg <= 1'b0;
            pixel         <= '0;
            pixel_vld     <= 1'b0;
            pixel_sop     <= 1'b0;
            pixel_eop     <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            din_reg       <= cmos_din;
            vsync_reg     <= cmos_vsync;
            vsync_dly_reg <= vsync_reg;
            href_reg      <= cmos_href;
            href_dly_reg  <= href_reg;

            if (skip_clr) begin
                skip_cnt_reg <= '0;
            end else if (skip_inc) begin
                skip_cnt_reg <= skip_cnt_reg + S_W'(1);
            end

            if (frame_start) begin
                x_reg    <= '0;
                y_reg    <= '0;
                beat_reg <= '0;
                bad_reg  <= 1'b0;
            end else if (beat_ok) begin
                asm_reg <= (asm_reg << IN_W) | PIX_W'(din_reg);
                if (pix_done) begin
                    beat_reg <= '0;
                    x_reg    <= x_reg + X_W'(1);
                end else begin
                    beat_reg <= beat_reg + B_W'(1);
                end
            end else if (beat_over) begin
                bad_reg <= 1'b1;
            end else if (line_end) begin
                x_reg    <= '0;
                beat_reg <= '0;
                if (y_reg != Y_FULL) begin
                    y_reg <= y_reg + Y_W'(1);
                end
                if (line_bad) begin
                    bad_reg <= 1'b1;
                end
            end

            // Stage 1: strobes aligned with the freshly assembled pixel
            emit_reg      <= pix_done;
            sop_stage_reg <= pix_done && (x_reg == '0) && (y_reg == '0);
            eop_stage_reg <= eop_hit;
            err_stage_reg <= abort || (eop_hit && bad_reg);

            // Stage 2: outputs
            if (emit_reg) begin
                pixel <= asm_reg;
            end
            pixel_vld <= emit_reg;
            pixel_sop <= sop_stage_reg;
            pixel_eop <= eop_stage_reg;
            frame_err <= err_stage_reg;
        end
    end

`ifdef CAP_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (frame_err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule
